// File: rtl/multi_ring_osc_gen_if.sv
// Configuration bus for multi_ring_osc_gen.
// The master drives per-channel config writes and the oscillator block receives them.
interface multi_ring_osc_gen_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic                  cfg_we;
    logic [$clog2(CH):0]   cfg_ch;
    logic [CNT_W-1:0]      cfg_half;
    logic [CNT_W-1:0]      cfg_burst;

    modport master (output cfg_we, cfg_ch, cfg_half, cfg_burst);
    modport slave  (input  cfg_we, cfg_ch, cfg_half, cfg_burst);
endinterface

// File: rtl/multi_ring_osc_gen.sv
// multi_ring_osc_gen: clocked multi-channel square-wave generator.
// Each channel has a programmable half-period and can either run free or emit a burst
// of full periods. Config writes go through the slave modport of multi_ring_osc_gen_if.
// Optional feature macro: OSC_PERIOD_CNT_EN adds the per-channel period_cnt output.
module multi_ring_osc_gen #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic [CH-1:0]        en,
    multi_ring_osc_gen_if.slave  cfg,
    output logic [CH-1:0]        pulse,
    output logic [CH-1:0]        busy,
    output logic [CH-1:0]        done
`ifdef OSC_PERIOD_CNT_EN
    ,
    output logic [CH*16-1:0]     period_cnt
`endif
);

    localparam int CH_W = $clog2(CH) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q [CH];
    state_e           state_d [CH];
    logic [CNT_W-1:0] half_q  [CH];
    logic [CNT_W-1:0] half_d  [CH];
    logic [CNT_W-1:0] burst_q [CH];
    logic [CNT_W-1:0] burst_d [CH];
    logic [CNT_W-1:0] ld_half [CH];
    logic [CNT_W-1:0] sh_h_q  [CH];
    logic [CNT_W-1:0] sh_h_d  [CH];
    logic [CNT_W-1:0] sh_b_q  [CH];
    logic [CNT_W-1:0] sh_b_d  [CH];
    logic [CNT_W-1:0] hcnt_q  [CH];
    logic [CNT_W-1:0] hcnt_d  [CH];
    logic [CNT_W-1:0] pcnt_q  [CH];
    logic [CNT_W-1:0] pcnt_d  [CH];
`ifdef OSC_PERIOD_CNT_EN
    logic [15:0]      pc_q    [CH];
    logic [15:0]      pc_d    [CH];
`endif

    logic [CH-1:0] en_q, en_d;
    logic [CH-1:0] pulse_q, pulse_d;
    logic [CH-1:0] busy_q, busy_d;
    logic [CH-1:0] done_q, done_d;

    // Config register write; the next-state value doubles as the forwarded value so a
    // write in the same cycle as a start or period start is picked up immediately.
    always_comb begin
        for (int unsigned i = 0; i < CH; i++) begin
            half_d[i]  = half_q[i];
            burst_d[i] = burst_q[i];
            if (cfg.cfg_we && (cfg.cfg_ch == CH_W'(i))) begin
                half_d[i]  = cfg.cfg_half;
                burst_d[i] = cfg.cfg_burst;
            end
            ld_half[i] = (half_d[i] == '0) ? CNT_W'(1) : half_d[i];
        end
    end

    // Per-channel IDLE/RUN next-state and output computation.
    always_comb begin
        en_d = en;
        for (int unsigned i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            sh_h_d[i]  = sh_h_q[i];
            sh_b_d[i]  = sh_b_q[i];
            hcnt_d[i]  = hcnt_q[i];
            pcnt_d[i]  = pcnt_q[i];
            pulse_d[i] = pulse_q[i];
            done_d[i]  = 1'b0;
`ifdef OSC_PERIOD_CNT_EN
            pc_d[i]    = pc_q[i];
`endif
            case (state_q[i])
                S_IDLE: begin
                    pulse_d[i] = 1'b0;
                    if (en[i] && !en_q[i]) begin
                        state_d[i] = S_RUN;
                        sh_h_d[i]  = ld_half[i];
                        sh_b_d[i]  = burst_d[i];
                        hcnt_d[i]  = '0;
                        pcnt_d[i]  = '0;
                        pulse_d[i] = 1'b1;
`ifdef OSC_PERIOD_CNT_EN
                        pc_d[i]    = '0;
`endif
                    end
                end
                S_RUN: begin
                    if (!en[i]) begin
                        state_d[i] = S_IDLE;
                        pulse_d[i] = 1'b0;
                    end else if (hcnt_q[i] == sh_h_q[i] - CNT_W'(1)) begin
                        hcnt_d[i] = '0;
                        if (pulse_q[i]) begin
                            pulse_d[i] = 1'b0;
                        end else begin
                            // Period counter saturates so a shrunken burst length still
                            // terminates at the next period end instead of wrapping.
                            pcnt_d[i] = (&pcnt_q[i]) ? pcnt_q[i] : pcnt_q[i] + CNT_W'(1);
`ifdef OSC_PERIOD_CNT_EN
                            pc_d[i]   = (&pc_q[i]) ? pc_q[i] : pc_q[i] + 16'd1;
`endif
                            if ((sh_b_q[i] != '0) && (pcnt_d[i] >= sh_b_q[i])) begin
                                state_d[i] = S_IDLE;
                                pulse_d[i] = 1'b0;
                                done_d[i]  = 1'b1;
                            end else begin
                                pulse_d[i] = 1'b1;
                                sh_h_d[i]  = ld_half[i];
                                sh_b_d[i]  = burst_d[i];
                            end
                        end
                    end else begin
                        hcnt_d[i] = hcnt_q[i] + CNT_W'(1);
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
            busy_d[i] = (state_d[i] == S_RUN);
        end
    end

    // State and registered outputs; init overrides everything.
    always_ff @(posedge clk) begin
        if (init) begin
            en_q    <= '0;
            pulse_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            for (int unsigned i = 0; i < CH; i++) begin
                state_q[i] <= S_IDLE;
                half_q[i]  <= CNT_W'(1);
                burst_q[i] <= '0;
                sh_h_q[i]  <= CNT_W'(1);
                sh_b_q[i]  <= '0;
                hcnt_q[i]  <= '0;
                pcnt_q[i]  <= '0;
`ifdef OSC_PERIOD_CNT_EN
                pc_q[i]    <= '0;
`endif
            end
        end else begin
            en_q    <= en_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int unsigned i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                half_q[i]  <= half_d[i];
                burst_q[i] <= burst_d[i];
                sh_h_q[i]  <= sh_h_d[i];
                sh_b_q[i]  <= sh_b_d[i];
                hcnt_q[i]  <= hcnt_d[i];
                pcnt_q[i]  <= pcnt_d[i];
`ifdef OSC_PERIOD_CNT_EN
                pc_q[i]    <= pc_d[i];
`endif
            end
        end
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef OSC_PERIOD_CNT_EN
    // Flatten per-channel period counters onto the output bus.
    always_comb begin
        period_cnt = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            period_cnt[i*16 +: 16] = pc_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_multi_ring_osc_gen.sv
// Testbench for multi_ring_osc_gen: directed scenarios plus randomized traffic,
// every cycle compared against a phase-based behavioural model of each channel.
module tb_multi_ring_osc_gen;

    localparam int CH    = 4;
    localparam int CNT_W = 8;

    logic          clk = 1'b0;
    logic          init;
    logic [CH-1:0] en;
    logic [CH-1:0] pulse, busy, done;
`ifdef OSC_PERIOD_CNT_EN
    logic [CH*16-1:0] period_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    multi_ring_osc_gen_if #(.CH(CH), .CNT_W(CNT_W)) cfg_if ();

    multi_ring_osc_gen #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .init      (init),
        .en        (en),
        .cfg       (cfg_if),
        .pulse     (pulse),
        .busy      (busy),
        .done      (done)
`ifdef OSC_PERIOD_CNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: each running channel tracks its position t within a 2H period.
    int m_run [CH];
    int m_t   [CH];
    int m_h   [CH];
    int m_b   [CH];
    int m_np  [CH];
    int m_pc  [CH];
    int m_ch  [CH];
    int m_cb  [CH];
    int m_enp [CH];
    logic [CH-1:0]    e_pulse, e_busy, e_done;
    logic [CH*16-1:0] e_pc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (init) begin
            for (int c = 0; c < CH; c++) begin
                m_run[c] = 0; m_t[c] = 0; m_np[c] = 0; m_pc[c] = 0;
                m_ch[c] = 1; m_cb[c] = 0; m_enp[c] = 0;
            end
            e_pulse = '0; e_busy = '0; e_done = '0; e_pc = '0;
        end else begin
            if (cfg_if.cfg_we && int'(cfg_if.cfg_ch) < CH) begin
                m_ch[cfg_if.cfg_ch] = int'(cfg_if.cfg_half);
                m_cb[cfg_if.cfg_ch] = int'(cfg_if.cfg_burst);
            end
            for (int c = 0; c < CH; c++) begin
                e_done[c] = 1'b0;
                if (m_run[c] == 0) begin
                    if (en[c] && m_enp[c] == 0) begin
                        m_run[c] = 1; m_t[c] = 0; m_np[c] = 0; m_pc[c] = 0;
                        m_h[c] = (m_ch[c] == 0) ? 1 : m_ch[c];
                        m_b[c] = m_cb[c];
                    end
                end else if (!en[c]) begin
                    m_run[c] = 0;
                end else begin
                    m_t[c]++;
                    if (m_t[c] == 2 * m_h[c]) begin
                        m_t[c] = 0;
                        m_np[c]++;
                        if (m_pc[c] < 65535) m_pc[c]++;
                        if (m_b[c] != 0 && m_np[c] >= m_b[c]) begin
                            m_run[c] = 0;
                            e_done[c] = 1'b1;
                        end else begin
                            m_h[c] = (m_ch[c] == 0) ? 1 : m_ch[c];
                            m_b[c] = m_cb[c];
                        end
                    end
                end
                m_enp[c]   = en[c] ? 1 : 0;
                e_pulse[c] = (m_run[c] != 0) && (m_t[c] < m_h[c]);
                e_busy[c]  = (m_run[c] != 0);
                e_pc[c*16 +: 16] = 16'(m_pc[c]);
            end
        end
    endtask

    // One clock: model consumes the same inputs the DUT samples, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pulse", 64'(pulse), 64'(e_pulse));
        check("busy",  64'(busy),  64'(e_busy));
        check("done",  64'(done),  64'(e_done));
`ifdef OSC_PERIOD_CNT_EN
        check("period_cnt", 64'(period_cnt), 64'(e_pc));
`endif
    endtask

    task automatic cfg_write(input int ch, input int half, input int burst);
        cfg_if.cfg_we    = 1'b1;
        cfg_if.cfg_ch    = ($clog2(CH)+1)'(ch);
        cfg_if.cfg_half  = CNT_W'(half);
        cfg_if.cfg_burst = CNT_W'(burst);
        tick();
        cfg_if.cfg_we    = 1'b0;
    endtask

    initial begin
        int runc;
        bit seen;
        logic exp_b;

        init = 1'b1;
        en   = '0;
        cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_half = '0; cfg_if.cfg_burst = '0;
        tick();
        tick();
        check("reset_outputs", {pulse, busy, done}, '0);
        init = 1'b0;
        tick();

        // Scenario 1: ch0 H=3 B=2, en rises in cycle 0.
        cfg_write(0, 3, 2);
        en[0] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp_b = ((k >= 1 && k <= 3) || (k >= 7 && k <= 9));
            check("t1_pulse0", pulse[0], exp_b);
            check("t1_busy0",  busy[0],  (k >= 1 && k <= 12));
            check("t1_done0",  done[0],  (k == 13));
        end

        // Scenario 2: ch1 H=0 B=4 toggles every cycle for 4 periods.
        cfg_write(1, 0, 4);
        en[1] = 1'b1;
        runc = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (busy[1]) runc++;
            if (done[1]) seen = 1'b1;
        end
        check("t2_done_seen", seen, 1'b1);
        check("t2_run_cycles", runc, 8);
        en[1] = 1'b0;
        tick();

        // Scenario 3: ch1 H=2 and ch2 H=5 free-run; abort ch1 in a high half.
        cfg_write(1, 2, 0);
        cfg_write(2, 5, 0);
        en[1] = 1'b1; en[2] = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        check("t3_pulse1_high", pulse[1], 1'b1);
        en[1] = 1'b0;
        tick();
        check("t3_abort_pulse1", pulse[1], 1'b0);
        check("t3_abort_busy1",  busy[1],  1'b0);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("t3_no_done1", done[1], 1'b0);
        end
        en[2] = 1'b0;
        tick();

        // Scenario 4: ch0 H=4 free-run, write H=2 in cycle 2 of the first high half.
        en[0] = 1'b0;
        tick();
        cfg_write(0, 4, 0);
        en[0] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 3) cfg_if.cfg_we = 1'b0;
            if (k <= 4)      exp_b = 1'b1;
            else if (k <= 8) exp_b = 1'b0;
            else             exp_b = (((k - 9) / 2) % 2) == 0;
            check("t4_pulse0", pulse[0], exp_b);
            if (k == 2) begin
                cfg_if.cfg_we = 1'b1; cfg_if.cfg_ch = '0;
                cfg_if.cfg_half = 8'd2; cfg_if.cfg_burst = 8'd0;
            end
        end

        // Scenario 5: init mid-burst with en[3] held high.
        cfg_write(3, 3, 5);
        en[3] = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        init = 1'b1;
        tick();
        check("t5_init_pulse", pulse, '0);
        check("t5_init_busy",  busy,  '0);
        check("t5_init_done",  done,  '0);
`ifdef OSC_PERIOD_CNT_EN
        check("t5_init_pcnt", period_cnt, '0);
`endif
        init = 1'b0;
        tick();
        check("t5_restart_p1", pulse[3], 1'b1);
        check("t5_restart_b",  busy[3],  1'b1);
        tick();
        check("t5_restart_p2", pulse[3], 1'b0);
        tick();
        check("t5_restart_p3", pulse[3], 1'b1);

`ifdef OSC_PERIOD_CNT_EN
        // Scenario 6: period count of a 3-period burst, held in IDLE, cleared on restart.
        en = '0;
        tick();
        cfg_write(0, 1, 3);
        en[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (done[0]) seen = 1'b1;
        end
        check("t6_done_seen", seen, 1'b1);
        check("t6_pcnt_done", period_cnt[15:0], 16'd3);
        for (int k = 0; k < 3; k++) tick();
        check("t6_pcnt_hold", period_cnt[15:0], 16'd3);
        en[0] = 1'b0;
        tick();
        en[0] = 1'b1;
        tick();
        check("t6_pcnt_clear", period_cnt[15:0], 16'd0);
`endif

        // Randomized traffic: en toggles, config writes (incl. out-of-range channels), rare init.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                int c;
                c = $urandom_range(0, CH - 1);
                en[c] = ~en[c];
            end
            if ($urandom_range(0, 7) == 0) begin
                cfg_if.cfg_we    = 1'b1;
                cfg_if.cfg_ch    = ($clog2(CH)+1)'($urandom_range(0, 7));
                cfg_if.cfg_half  = CNT_W'($urandom_range(0, 4));
                cfg_if.cfg_burst = CNT_W'($urandom_range(0, 3));
            end else begin
                cfg_if.cfg_we = 1'b0;
            end
            init = ($urandom_range(0, 499) == 0);
            tick();
        end
        init = 1'b0;
        cfg_if.cfg_we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
